// File: rtl/global_regs_tx_pkg.sv
// Shared definitions for the global-register byte link: widths, byte slots and FSM encoding.
// The receiver side imports the same package so both ends agree on frame layout.
package global_regs_tx_pkg;

    localparam int DATA_W    = 8;
    localparam int NUM_BYTES = 4;
    localparam int BC_W      = 4;
    localparam int IDX_W     = $clog2(NUM_BYTES);

    localparam int GR_NUM_BYTES = NUM_BYTES;
    localparam int GR_IDX_X     = 0;
    localparam int GR_IDX_Y     = 1;
    localparam int GR_IDX_ANGLE = 2;
    localparam int GR_IDX_ZOOM  = 3;

    typedef enum logic [1:0] {
        GR_IDLE = 2'd0,
        GR_SEND = 2'd1,
        GR_DONE = 2'd2
    } gr_state_e;

endpackage

// File: rtl/gr_shadow_mux.sv
// Capture-enabled shadow bank holding one frame of parameters, with an index-selected byte read.
// Out-of-range indices read as zero so the caller may look one slot past the last byte.
module gr_shadow_mux
    import global_regs_tx_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               capture_i,
    input  logic [NUM_BYTES-1:0][DATA_W-1:0]   data_i,
    input  logic [BC_W-1:0]                    sel_i,
    output logic [DATA_W-1:0]                  byte_o
);

    logic [NUM_BYTES-1:0][DATA_W-1:0] shadow_w;

    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : gen_bank
            logic [DATA_W-1:0] shadow_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_q <= '0;
                end else if (capture_i) begin
                    shadow_q <= data_i[gi];
                end
            end

            assign shadow_w[gi] = shadow_q;
        end
    endgenerate

    always_comb begin
        byte_o = '0;
        if (sel_i < BC_W'(NUM_BYTES)) begin
            byte_o = shadow_w[sel_i[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/global_regs_tx.sv
// Transmit side of the global-register byte link: snapshots four parameters on START and
// streams them one byte per VALID/NEXT transfer, pulsing FINISH once the frame completes.
module global_regs_tx
    import global_regs_tx_pkg::*;
(
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              START,
    input  logic              ABORT,
    input  logic [DATA_W-1:0] X_center,
    input  logic [DATA_W-1:0] Y_center,
    input  logic [DATA_W-1:0] Angle,
    input  logic [DATA_W-1:0] Zoom,
    input  logic              NEXT,
    output logic [DATA_W-1:0] WByt0,
    output logic              VALID,
    output logic [BC_W-1:0]   BC,
    output logic              BUSY,
    output logic              FINISH
);

    gr_state_e         state_q, state_d;
    logic [DATA_W-1:0] wbyt_q, wbyt_d;
    logic              valid_q, valid_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic              busy_q, busy_d;
    logic              finish_q, finish_d;

    logic                             capture;
    logic                             transfer;
    logic                             last_byte;
    logic [BC_W-1:0]                  next_idx;
    logic [DATA_W-1:0]                next_byte;
    logic [NUM_BYTES-1:0][DATA_W-1:0] cap_data;

    assign cap_data[GR_IDX_X]     = X_center;
    assign cap_data[GR_IDX_Y]     = Y_center;
    assign cap_data[GR_IDX_ANGLE] = Angle;
    assign cap_data[GR_IDX_ZOOM]  = Zoom;

    assign capture   = (state_q == GR_IDLE) && START && !ABORT;
    assign transfer  = valid_q && NEXT;
    assign last_byte = (bc_q == BC_W'(NUM_BYTES - 1));
    // Prefetch the byte after the current one so a transfer can update WByt0 gaplessly.
    assign next_idx  = bc_q + BC_W'(1);

    gr_shadow_mux u_shadow (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .capture_i (capture),
        .data_i    (cap_data),
        .sel_i     (next_idx),
        .byte_o    (next_byte)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= GR_IDLE;
            wbyt_q   <= '0;
            valid_q  <= 1'b0;
            bc_q     <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wbyt_q   <= wbyt_d;
            valid_q  <= valid_d;
            bc_q     <= bc_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            GR_IDLE: if (capture) state_d = GR_SEND;
            GR_SEND: begin
                if (ABORT) begin
                    state_d = GR_IDLE;
                end else if (transfer && last_byte) begin
                    state_d = GR_DONE;
                end
            end
            GR_DONE: state_d = GR_IDLE;
            default: state_d = GR_IDLE;
        endcase
    end

    always_comb begin
        wbyt_d   = '0;
        valid_d  = 1'b0;
        bc_d     = '0;
        busy_d   = 1'b0;
        finish_d = 1'b0;
        case (state_q)
            GR_IDLE: begin
                if (capture) begin
                    wbyt_d  = X_center;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            GR_SEND: begin
                // ABORT outranks a same-edge transfer: that byte is treated as not sent.
                if (ABORT) begin
                    wbyt_d = '0;
                end else if (transfer && last_byte) begin
                    finish_d = 1'b1;
                    busy_d   = 1'b1;
                end else if (transfer) begin
                    wbyt_d  = next_byte;
                    valid_d = 1'b1;
                    bc_d    = next_idx;
                    busy_d  = 1'b1;
                end else begin
                    wbyt_d  = wbyt_q;
                    valid_d = 1'b1;
                    bc_d    = bc_q;
                    busy_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign WByt0  = wbyt_q;
    assign VALID  = valid_q;
    assign BC     = bc_q;
    assign BUSY   = busy_q;
    assign FINISH = finish_q;

endmodule

// File: tb/tb_global_regs_tx.sv
// Self-checking bench for global_regs_tx: directed frame scenarios plus a randomized run
// scored against a transaction-level model of frames, bytes and FINISH pulses.
module tb_global_regs_tx;

    logic       ACLK = 1'b0;
    logic       ARESETn = 1'b0;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic [7:0] X_center = '0;
    logic [7:0] Y_center = '0;
    logic [7:0] Angle = '0;
    logic [7:0] Zoom = '0;
    logic       NEXT = 1'b0;
    logic [7:0] WByt0;
    logic       VALID;
    logic [3:0] BC;
    logic       BUSY;
    logic       FINISH;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 ACLK = ~ACLK;

    global_regs_tx dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .START    (START),
        .ABORT    (ABORT),
        .X_center (X_center),
        .Y_center (Y_center),
        .Angle    (Angle),
        .Zoom     (Zoom),
        .NEXT     (NEXT),
        .WByt0    (WByt0),
        .VALID    (VALID),
        .BC       (BC),
        .BUSY     (BUSY),
        .FINISH   (FINISH)
    );

    task automatic set_regs(input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] a, input logic [7:0] z);
        X_center = x; Y_center = y; Angle = a; Zoom = z;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            n_cmp++;
            if ({WByt0, VALID, BC, BUSY, FINISH} !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_hold: got W=%h V=%b BC=%0d B=%b F=%b want all 0",
                         WByt0, VALID, BC, BUSY, FINISH);
            end
        end
        ARESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            NEXT = ~NEXT;
            @(negedge ACLK);
            n_cmp++;
            if ({WByt0, VALID, BC, BUSY, FINISH} !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_idle_next: got W=%h V=%b BC=%0d B=%b F=%b want all 0",
                         WByt0, VALID, BC, BUSY, FINISH);
            end
        end
        NEXT = 1'b0;
        $display("reset: idle after release");
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        set_regs(8'h11, 8'h22, 8'h33, 8'h44);
        START = 1'b1; NEXT = 1'b1;
        @(negedge ACLK);
        START = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (VALID !== 1'b1 || BC !== 4'(k) || WByt0 !== exp_b[k] || FINISH !== 1'b0 || BUSY !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_byte%0d: got V=%b BC=%0d W=%h F=%b B=%b want V=1 BC=%0d W=%h F=0 B=1",
                         k, VALID, BC, WByt0, FINISH, BUSY, k, exp_b[k]);
            end
            $display("basic: byte bc=%0d data=%h", BC, WByt0);
            @(negedge ACLK);
        end
        n_cmp++;
        if (FINISH !== 1'b1 || VALID !== 1'b0 || BC !== 4'd0 || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_finish: got F=%b V=%b BC=%0d B=%b want F=1 V=0 BC=0 B=1",
                     FINISH, VALID, BC, BUSY);
        end
        @(negedge ACLK);
        n_cmp++;
        if (FINISH !== 1'b0 || BUSY !== 1'b0 || VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got F=%b B=%b V=%b want 0 0 0", FINISH, BUSY, VALID);
        end
        NEXT = 1'b0;
    endtask

    task automatic test_stall();
        logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        set_regs(8'h11, 8'h22, 8'h33, 8'h44);
        START = 1'b1; NEXT = 1'b1;
        @(negedge ACLK);
        START = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (VALID !== 1'b1 || BC !== 4'(k) || WByt0 !== exp_b[k]) begin
                n_fail++;
                $display("FAIL stall_byte%0d: got V=%b BC=%0d W=%h want V=1 BC=%0d W=%h",
                         k, VALID, BC, WByt0, k, exp_b[k]);
            end
            if (k == 1) begin
                NEXT = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge ACLK);
                    n_cmp++;
                    if (VALID !== 1'b1 || BC !== 4'd1 || WByt0 !== 8'h22) begin
                        n_fail++;
                        $display("FAIL stall_hold%0d: got V=%b BC=%0d W=%h want V=1 BC=1 W=22",
                                 s, VALID, BC, WByt0);
                    end
                end
                NEXT = 1'b1;
            end
            $display("stall: byte bc=%0d data=%h", BC, WByt0);
            @(negedge ACLK);
        end
        n_cmp++;
        if (FINISH !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_finish: got F=%b want 1", FINISH);
        end
        @(negedge ACLK);
        NEXT = 1'b0;
    endtask

    task automatic test_capture();
        logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        set_regs(8'h11, 8'h22, 8'h33, 8'h44);
        START = 1'b1; NEXT = 1'b1;
        @(negedge ACLK);
        START = 1'b0;
        set_regs(8'hAA, 8'hAA, 8'hAA, 8'hAA);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (VALID !== 1'b1 || BC !== 4'(k) || WByt0 !== exp_b[k]) begin
                n_fail++;
                $display("FAIL capture_byte%0d: got V=%b BC=%0d W=%h want V=1 BC=%0d W=%h",
                         k, VALID, BC, WByt0, k, exp_b[k]);
            end
            $display("capture: byte bc=%0d data=%h", BC, WByt0);
            START = (k == 1);
            @(negedge ACLK);
        end
        START = 1'b0;
        n_cmp++;
        if (FINISH !== 1'b1) begin
            n_fail++;
            $display("FAIL capture_finish: got F=%b want 1", FINISH);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            n_cmp++;
            if (VALID !== 1'b0 || BUSY !== 1'b0 || FINISH !== 1'b0) begin
                n_fail++;
                $display("FAIL capture_no_requeue%0d: got V=%b B=%b F=%b want 0 0 0",
                         i, VALID, BUSY, FINISH);
            end
        end
        NEXT = 1'b0;
    endtask

    task automatic test_abort();
        int guard;
        set_regs(8'h11, 8'h22, 8'h33, 8'h44);
        START = 1'b1; NEXT = 1'b1;
        @(negedge ACLK);
        START = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        n_cmp++;
        if (BC !== 4'd2 || WByt0 !== 8'h33) begin
            n_fail++;
            $display("FAIL abort_pre: got BC=%0d W=%h want BC=2 W=33", BC, WByt0);
        end
        ABORT = 1'b1;
        @(negedge ACLK);
        ABORT = 1'b0;
        n_cmp++;
        if (VALID !== 1'b0 || BUSY !== 1'b0 || BC !== 4'd0 || FINISH !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got V=%b B=%b BC=%0d F=%b want 0 0 0 0", VALID, BUSY, BC, FINISH);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            n_cmp++;
            if (FINISH !== 1'b0 || VALID !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_finish%0d: got F=%b V=%b want 0 0", i, FINISH, VALID);
            end
        end
        $display("abort: frame cancelled at bc=2");
        set_regs(8'h55, 8'h66, 8'h77, 8'h88);
        START = 1'b1;
        @(negedge ACLK);
        START = 1'b0;
        n_cmp++;
        if (VALID !== 1'b1 || BC !== 4'd0 || WByt0 !== 8'h55) begin
            n_fail++;
            $display("FAIL abort_restart: got V=%b BC=%0d W=%h want V=1 BC=0 W=55", VALID, BC, WByt0);
        end
        guard = 0;
        while (BUSY === 1'b1 && guard < 20) begin
            @(negedge ACLK);
            guard++;
        end
        n_cmp++;
        if (guard >= 20) begin
            n_fail++;
            $display("FAIL abort_drain: BUSY still %b after %0d cycles want 0", BUSY, guard);
        end
        NEXT = 1'b0;
    endtask

    task automatic test_async_reset();
        set_regs(8'h11, 8'h22, 8'h33, 8'h44);
        START = 1'b1; NEXT = 1'b1;
        @(negedge ACLK);
        START = 1'b0;
        @(negedge ACLK);
        n_cmp++;
        if (BC !== 4'd1 || VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: got BC=%0d V=%b want BC=1 V=1", BC, VALID);
        end
        #2 ARESETn = 1'b0;
        #1;
        n_cmp++;
        if ({WByt0, VALID, BC, BUSY, FINISH} !== 16'h0) begin
            n_fail++;
            $display("FAIL areset_immediate: got W=%h V=%b BC=%0d B=%b F=%b want all 0",
                     WByt0, VALID, BC, BUSY, FINISH);
        end
        @(negedge ACLK);
        ARESETn = 1'b1;
        NEXT = 1'b0;
        @(negedge ACLK);
        START = 1'b1; ABORT = 1'b1;
        @(negedge ACLK);
        START = 1'b0; ABORT = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (VALID !== 1'b0 || BUSY !== 1'b0 || FINISH !== 1'b0) begin
                n_fail++;
                $display("FAIL start_abort_idle%0d: got V=%b B=%b F=%b want 0 0 0", i, VALID, BUSY, FINISH);
            end
            @(negedge ACLK);
        end
        $display("areset: cleared mid-frame, START+ABORT ignored");
    endtask

    // Frame-level model: a captured 4-byte frame, how many bytes have been accepted,
    // and whether a FINISH pulse is owed for the current cycle.
    task automatic test_random();
        logic [7:0] frame [4];
        bit         active = 0;
        bit         fin    = 0;
        int         sent   = 0;
        int         frames = 0;
        for (int c = 0; c < 400; c++) begin
            n_cmp++;
            if (VALID !== active || BUSY !== (active | fin) || FINISH !== fin ||
                (active && (BC !== 4'(sent) || WByt0 !== frame[sent])) ||
                (!active && BC !== 4'd0)) begin
                n_fail++;
                $display("FAIL random_c%0d: got V=%b B=%b F=%b BC=%0d W=%h want V=%b B=%b F=%b BC=%0d W=%h",
                         c, VALID, BUSY, FINISH, BC, WByt0, active, active | fin, fin,
                         active ? sent : 0, active ? frame[sent] : 8'h00);
            end
            START = ($urandom_range(0, 3) == 0);
            ABORT = ($urandom_range(0, 15) == 0);
            NEXT  = ($urandom_range(0, 2) != 0);
            set_regs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            if (fin) begin
                fin = 0;
            end else if (!active) begin
                if (START && !ABORT) begin
                    frame = '{X_center, Y_center, Angle, Zoom};
                    active = 1;
                    sent = 0;
                end
            end else if (ABORT) begin
                active = 0;
                sent = 0;
            end else if (NEXT) begin
                $display("random: xfer bc=%0d data=%h", sent, frame[sent]);
                if (sent == 3) begin
                    active = 0;
                    fin = 1;
                    sent = 0;
                    frames++;
                end else begin
                    sent++;
                end
            end
            @(negedge ACLK);
        end
        START = 1'b0; ABORT = 1'b0; NEXT = 1'b0;
        $display("random: %0d frames completed", frames);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_capture();
        test_abort();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
